tt_um_rps_match: RTL and testbench
==================================

TT_UM_RPS_MATCH -- requirements
Module: tt_um_rps_match

Interface
REQ-001 SHALL have parameter WIN_TARGET, default 3: round wins needed to take the match; legal range 1..15.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000: forfeit window in clk cycles; legal range 1..65535; used only when RPS_TIMEOUT_EN is defined.
REQ-003 SHALL have port clk, input, 1: the only clock.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port ena, input, 1: when low, all state holds and no commit or new-match edge is registered.
REQ-006 SHALL have port ui_in, input, 8, mapped as follows: [1:0] P1 move; [2] P1 commit; [4:3] P2 move; [5] P2 commit; [6] new_match; [7] unused.
REQ-007 SHALL have port uo_out, output, 8, mapped as follows: [1:0] last result; [3:2] state; [4] P1 committed; [5] P2 committed; [6] match_over; [7] last round was a forfeit.
REQ-008 SHALL have port uio_in, input, 8: unused.
REQ-009 SHALL have port uio_out, output, 8, mapped as follows: [3:0] P1 score; [7:4] P2 score.
REQ-010 SHALL drive uio_oe, output, 8, constant 8'hFF.

Function
REQ-011 Move encoding SHALL be 00 stone, 01 paper, 10 scissors, 11 invalid.
REQ-012 Result encoding SHALL be 00 tie, 01 P1 wins, 10 P2 wins, 11 invalid.
REQ-013 Each of ui_in[2], ui_in[5] and ui_in[6] SHALL pass through a 2-flop synchroniser followed by a rising-edge detector.
REQ-014 A pin first sampled high at edge N SHALL produce a one-cycle edge pulse that takes effect at edge N+2.
REQ-015 State SHALL be one of WAIT=00, RESOLVE=01, DONE=10; encoding 11 is unused.
REQ-016 In WAIT, a commit edge for an uncommitted player SHALL latch that player's move and set the player's committed flag.
REQ-017 A commit edge for an already-committed player SHALL be ignored; the latched move is never overwritten.
REQ-018 Simultaneous commit edges from both players SHALL latch both moves in the same cycle.
REQ-019 In WAIT, with both committed flags set, the block SHALL go to RESOLVE on the next edge.
REQ-020 In RESOLVE (one cycle), the block SHALL compute the winner from the latched moves: stone beats scissors, scissors beat paper, paper beats stone, equal moves tie.
REQ-021 If either latched move is 11, the result SHALL be 11 and no score changes.
REQ-022 When RESOLVE exits, the result SHALL be registered, the winner's score incremented by 1, and both committed flags and the forfeit flag cleared.
REQ-023 When RESOLVE exits, the next state SHALL be DONE if a score equals WIN_TARGET, otherwise WAIT.
REQ-024 In DONE, match_over=1; scores and result SHALL hold; commit edges SHALL be ignored.
REQ-025 A new_match edge in any state SHALL clear scores, committed flags, result, forfeit and timer, and go to WAIT; it takes priority over a same-cycle commit, which is discarded.
REQ-026 Scores SHALL be 4 bits and cannot exceed WIN_TARGET, so no wrap is possible.
REQ-027 Commit edges arriving during RESOLVE SHALL be discarded.

Reset
REQ-028 On rst_n low, the block SHALL asynchronously enter state WAIT and clear all flags, scores, latched moves, synchronisers and the timer.
REQ-029 In reset, uo_out SHALL be 8'h00 and uio_out SHALL be 8'h00.
REQ-030 Reset asserted mid-round SHALL abandon the round with no score change.

Configuration
REQ-031 With RPS_TIMEOUT_EN defined, in WAIT with exactly one player committed, a counter SHALL run.
REQ-032 With RPS_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the committed player SHALL win the round: result set to that player, score incremented, forfeit=1, flags cleared, and the REQ-023 rule applied.
REQ-033 With RPS_TIMEOUT_EN defined, the counter SHALL clear whenever the second player commits or on new_match.
REQ-034 With RPS_TIMEOUT_EN defined, a second commit in the same cycle as expiry SHALL take priority over the timeout, and the round resolves normally.
REQ-035 Without RPS_TIMEOUT_EN, no counter SHALL exist, WAIT SHALL wait indefinitely, and uo_out[7] SHALL be constant 0.

Structure
REQ-036 Package rps_pkg SHALL hold the move codes, result codes, state encoding and a win_score width constant of 4.
REQ-037 Sub-module rps_sync_edge (2-flop synchroniser plus rising-edge pulse) SHALL be instantiated three times.

Verification
REQ-038 Bench SHALL cover: reset, then P1 commits 00 and P2 commits 10 -> result 01, P1 score 1, state WAIT two edges after the second flag sets.
REQ-039 Bench SHALL cover: P1 recommits 01 after committing 00, then P2 commits 01 -> P1 move stays 00, result 10.
REQ-040 Bench SHALL cover: with WIN_TARGET=2, P2 wins two rounds -> uio_out=8'h20, state DONE, match_over=1, and a further commit changes nothing.
REQ-041 Bench SHALL cover: both commits on the same edge with P1 move 11 -> result 11, scores unchanged.
REQ-042 Bench SHALL cover: new_match edge during DONE together with a commit edge -> scores 0, state WAIT, flags 0.
REQ-043 Bench SHALL cover, with RPS_TIMEOUT_EN and TIMEOUT_CYCLES=8: only P2 commits -> after 8 cycles result 10, forfeit=1, P2 score +1.

Source files
------------

// File: rtl/rps_pkg.sv
// rtl/rps_pkg.sv - shared codes, state encoding and round judge for the RPS match block
package rps_pkg;

  localparam int WIN_SCORE_W = 4;

  typedef enum logic [1:0] {
    MOVE_STONE    = 2'b00,
    MOVE_PAPER    = 2'b01,
    MOVE_SCISSORS = 2'b10,
    MOVE_INVALID  = 2'b11
  } move_t;

  typedef enum logic [1:0] {
    RES_TIE     = 2'b00,
    RES_P1      = 2'b01,
    RES_P2      = 2'b10,
    RES_INVALID = 2'b11
  } result_t;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'b00,
    ST_RESOLVE = 2'b01,
    ST_DONE    = 2'b10,
    ST_UNUSED  = 2'b11
  } state_t;

  // Round outcome for latched moves; any invalid move poisons the round.
  function automatic result_t rps_judge(input move_t a, input move_t b);
    result_t r;
    r = RES_TIE;
    if (a == MOVE_INVALID || b == MOVE_INVALID) begin
      r = RES_INVALID;
    end else if (a != b) begin
      case (a)
        MOVE_STONE:    r = (b == MOVE_SCISSORS) ? RES_P1 : RES_P2;
        MOVE_PAPER:    r = (b == MOVE_STONE)    ? RES_P1 : RES_P2;
        MOVE_SCISSORS: r = (b == MOVE_PAPER)    ? RES_P1 : RES_P2;
        default:       r = RES_INVALID;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/rps_sync_edge.sv
// rtl/rps_sync_edge.sv - two-flop synchroniser with a one-cycle rising-edge pulse
module rps_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic i_pin,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchroniser chain plus history flop; frozen while the tile is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else if (ena) begin
      r_meta <= i_pin;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = ena & r_sync & ~r_prev;

endmodule

// File: rtl/tt_um_rps_match.sv
// rtl/tt_um_rps_match.sv - rock-paper-scissors match controller (RPS_TIMEOUT_EN adds forfeit timer)
module tt_um_rps_match
  import rps_pkg::*;
#(
  parameter int WIN_TARGET     = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [WIN_SCORE_W-1:0] LP_TARGET = WIN_SCORE_W'(WIN_TARGET);

  logic w_commit1;
  logic w_commit2;
  logic w_new_match;

  state_t                 r_state,  w_state_nx;
  move_t                  r_move1,  w_move1_nx;
  move_t                  r_move2,  w_move2_nx;
  logic                   r_flag1,  w_flag1_nx;
  logic                   r_flag2,  w_flag2_nx;
  result_t                r_result, w_result_nx;
  logic [WIN_SCORE_W-1:0] r_score1, w_score1_nx;
  logic [WIN_SCORE_W-1:0] r_score2, w_score2_nx;

  logic    w_take1;
  logic    w_take2;
  logic    w_round_done;
  result_t w_round;
  logic    w_forfeit_out;
  logic    w_unused;

`ifdef RPS_TIMEOUT_EN
  localparam logic [15:0] LP_TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic        r_forfeit, w_forfeit_nx;
  logic [15:0] r_timer,   w_timer_nx;
  logic        w_forfeit_set;
`else
  localparam int lp_unused_timeout = TIMEOUT_CYCLES;
`endif

  rps_sync_edge u_sync_p1 (.clk(clk), .rst_n(rst_n), .ena(ena), .i_pin(ui_in[2]), .o_rise(w_commit1));
  rps_sync_edge u_sync_p2 (.clk(clk), .rst_n(rst_n), .ena(ena), .i_pin(ui_in[5]), .o_rise(w_commit2));
  rps_sync_edge u_sync_nm (.clk(clk), .rst_n(rst_n), .ena(ena), .i_pin(ui_in[6]), .o_rise(w_new_match));

  // Next-state and datapath decisions for the match FSM.
  always_comb begin
    w_state_nx   = r_state;
    w_move1_nx   = r_move1;
    w_move2_nx   = r_move2;
    w_flag1_nx   = r_flag1;
    w_flag2_nx   = r_flag2;
    w_result_nx  = r_result;
    w_score1_nx  = r_score1;
    w_score2_nx  = r_score2;
    w_take1      = 1'b0;
    w_take2      = 1'b0;
    w_round_done = 1'b0;
    w_round      = RES_TIE;
`ifdef RPS_TIMEOUT_EN
    w_forfeit_nx  = r_forfeit;
    w_timer_nx    = r_timer;
    w_forfeit_set = 1'b0;
`endif
    if (w_new_match) begin
      // New match wins over everything, including a same-cycle commit.
      w_state_nx  = ST_WAIT;
      w_flag1_nx  = 1'b0;
      w_flag2_nx  = 1'b0;
      w_result_nx = RES_TIE;
      w_score1_nx = '0;
      w_score2_nx = '0;
`ifdef RPS_TIMEOUT_EN
      w_forfeit_nx = 1'b0;
      w_timer_nx   = '0;
`endif
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (r_flag1 && r_flag2) begin
            w_state_nx = ST_RESOLVE;
`ifdef RPS_TIMEOUT_EN
            w_timer_nx = '0;
`endif
          end else begin
            w_take1 = w_commit1 & ~r_flag1;
            w_take2 = w_commit2 & ~r_flag2;
            if (w_take1) begin
              w_move1_nx = move_t'(ui_in[1:0]);
              w_flag1_nx = 1'b1;
            end
            if (w_take2) begin
              w_move2_nx = move_t'(ui_in[4:3]);
              w_flag2_nx = 1'b1;
            end
`ifdef RPS_TIMEOUT_EN
            // With one player in, any take is the opponent arriving, which beats expiry.
            if (r_flag1 ^ r_flag2) begin
              if (w_take1 | w_take2) begin
                w_timer_nx = '0;
              end else if (r_timer == LP_TIMER_LAST) begin
                w_round_done  = 1'b1;
                w_round       = r_flag1 ? RES_P1 : RES_P2;
                w_forfeit_set = 1'b1;
                w_timer_nx    = '0;
              end else begin
                w_timer_nx = r_timer + 16'd1;
              end
            end else begin
              w_timer_nx = '0;
            end
`endif
          end
        end
        ST_RESOLVE: begin
          w_round_done = 1'b1;
          w_round      = rps_judge(r_move1, r_move2);
        end
        ST_DONE: begin
          w_state_nx = ST_DONE;
        end
        default: begin
          w_state_nx = ST_WAIT;
        end
      endcase

      // Shared round close-out for normal resolution and forfeit.
      if (w_round_done) begin
        w_result_nx = w_round;
        if (w_round == RES_P1) w_score1_nx = r_score1 + 4'd1;
        if (w_round == RES_P2) w_score2_nx = r_score2 + 4'd1;
        w_flag1_nx = 1'b0;
        w_flag2_nx = 1'b0;
`ifdef RPS_TIMEOUT_EN
        w_forfeit_nx = w_forfeit_set;
`endif
        w_state_nx = (w_score1_nx == LP_TARGET || w_score2_nx == LP_TARGET) ? ST_DONE : ST_WAIT;
      end
    end
  end

  // State and datapath registers; everything holds while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_WAIT;
      r_move1  <= MOVE_STONE;
      r_move2  <= MOVE_STONE;
      r_flag1  <= 1'b0;
      r_flag2  <= 1'b0;
      r_result <= RES_TIE;
      r_score1 <= '0;
      r_score2 <= '0;
    end else if (ena) begin
      r_state  <= w_state_nx;
      r_move1  <= w_move1_nx;
      r_move2  <= w_move2_nx;
      r_flag1  <= w_flag1_nx;
      r_flag2  <= w_flag2_nx;
      r_result <= w_result_nx;
      r_score1 <= w_score1_nx;
      r_score2 <= w_score2_nx;
    end
  end

`ifdef RPS_TIMEOUT_EN
  // Forfeit flag and single-commit timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_forfeit <= 1'b0;
      r_timer   <= '0;
    end else if (ena) begin
      r_forfeit <= w_forfeit_nx;
      r_timer   <= w_timer_nx;
    end
  end
  assign w_forfeit_out = r_forfeit;
`else
  assign w_forfeit_out = 1'b0;
`endif

  assign uo_out   = {w_forfeit_out, (r_state == ST_DONE), r_flag2, r_flag1, r_state, r_result};
  assign uio_out  = {r_score2, r_score1};
  assign uio_oe   = 8'hFF;
  assign w_unused = &{1'b0, uio_in, ui_in[7]};

endmodule

// File: tb/tb_tt_um_rps_match.sv
// tb/tb_tt_um_rps_match.sv - scoreboard bench for tt_um_rps_match with a game-level model
module tb_tt_um_rps_match;

  localparam int WT = 2;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_rps_match #(.WIN_TARGET(WT), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] word;
    int          at;
  } exp_t;
  exp_t q[$];

  int total = 0;
  int bad = 0;

  // game model
  int s1, s2, f1, f2, m1, m2, res, ff, t1;
  bit done;
  logic [15:0] last_pushed;
  logic [15:0] mon_last = 16'h0000;
  bit mon_en = 1'b0;

  function automatic logic [15:0] mword(input logic [1:0] st);
    logic [7:0] uo;
    logic [7:0] uio;
    uo  = {ff[0], done, f2[0], f1[0], st, res[1:0]};
    uio = {s2[3:0], s1[3:0]};
    return {uio, uo};
  endfunction

  function automatic void push(input logic [15:0] w, input int at);
    if (w != last_pushed) begin
      q.push_back('{w, at});
      last_pushed = w;
    end
  endfunction

  function automatic int judge(input int a, input int b);
    if (a == 3 || b == 3) return 3;
    return (a - b + 3) % 3;
  endfunction

  function automatic void close_round(input int winner, input int forfeit, input int at);
    res = winner;
    if (winner == 1) s1++;
    if (winner == 2) s2++;
    f1 = 0;
    f2 = 0;
    ff = forfeit;
    done = (s1 == WT) || (s2 == WT);
    push(mword(done ? 2'd2 : 2'd0), at);
  endfunction

  function automatic void model_reset();
    s1 = 0; s2 = 0; f1 = 0; f2 = 0; m1 = 0; m2 = 0; res = 0; ff = 0; t1 = 0;
    done = 1'b0;
    last_pushed = 16'h0000;
    q.delete();
  endfunction

  function automatic void settle(input int upto);
`ifdef RPS_TIMEOUT_EN
    if (!done && (f1 != f2) && (t1 + TO <= upto))
      close_round((f1 != 0) ? 1 : 2, 1, t1 + TO);
`endif
  endfunction

  task automatic tick();
    @(negedge clk);
    settle(cyc + 2);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Drive commit / new_match pins for one pulse and predict the outcome.
  task automatic apply(input bit c1, input int mv1, input bit c2, input int mv2, input bit nm);
    int eff;
    bit a1, a2;
    eff = cyc + 3;
    if (c1) ui_in[1:0] = 2'(mv1);
    if (c2) ui_in[4:3] = 2'(mv2);
    ui_in[2] = c1;
    ui_in[5] = c2;
    ui_in[6] = nm;
    if (nm) begin
      s1 = 0; s2 = 0; f1 = 0; f2 = 0; res = 0; ff = 0; done = 1'b0;
      push(mword(2'd0), eff);
    end else if (!done) begin
      a1 = c1 && (f1 == 0);
      a2 = c2 && (f2 == 0);
      if (a1) begin f1 = 1; m1 = mv1; end
      if (a2) begin f2 = 1; m2 = mv2; end
      if (a1 || a2) begin
        push(mword(2'd0), eff);
        if (f1 != 0 && f2 != 0) begin
          push(mword(2'd1), eff + 1);
          close_round(judge(m1, m2), 0, eff + 2);
        end else begin
          t1 = eff;
        end
      end
    end
    tick();
    tick();
    ui_in[2] = 1'b0;
    ui_in[5] = 1'b0;
    ui_in[6] = 1'b0;
    tick();
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() > 0; i++) tick();
    total++;
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain pending=%0d next=%h", q.size(), q[0].word);
      q.delete();
    end
  endtask

  // Monitor: every change of the output word must be the next scoreboard entry, on time.
  always @(negedge clk) begin
    logic [15:0] w;
    exp_t e;
    if (mon_en) begin
      w = {uio_out, uo_out};
      if (w != mon_last) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change cyc=%0d act=%h exp=%h", cyc, w, mon_last);
        end else begin
          e = q.pop_front();
          if (e.word !== w || e.at != cyc) begin
            bad++;
            $display("FAIL out_word cyc=%0d act=%h exp=%h exp_cyc=%0d", cyc, w, e.word, e.at);
          end
        end
        mon_last = w;
      end else if (q.size() > 0 && q[0].at < cyc) begin
        total++;
        bad++;
        $display("FAIL missing_change cyc=%0d act=%h exp=%h exp_cyc=%0d", cyc, w, q[0].word, q[0].at);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, gap, first;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_uo", {8'h00, uo_out}, 16'h0000);
    chk("reset_uio", {8'h00, uio_out}, 16'h0000);
    chk("uio_oe", {8'h00, uio_oe}, 16'h00FF);
    rst_n = 1'b1;
    mon_last = 16'h0000;
    mon_en = 1'b1;
    tick();

    // stone vs scissors
    apply(1, 0, 0, 0, 0);
    apply(0, 0, 1, 2, 0);
    drain();
    chk("round1", {uio_out, uo_out}, 16'h0101);

    // recommit ignored, stone vs paper
    apply(1, 0, 0, 0, 0);
    apply(1, 1, 0, 0, 0);
    apply(0, 0, 1, 1, 0);
    drain();
    chk("recommit", {uio_out, uo_out}, 16'h1102);

    // simultaneous, P1 invalid
    apply(1, 3, 1, 0, 0);
    drain();
    chk("invalid", {uio_out, uo_out}, 16'h1103);

    // P2 takes the match
    apply(0, 0, 0, 0, 1);
    drain();
    for (int k = 0; k < 2; k++) begin
      apply(1, 0, 0, 0, 0);
      apply(0, 0, 1, 1, 0);
      drain();
    end
    chk("match_done", {uio_out, uo_out}, 16'h204A);
    apply(1, 1, 1, 2, 0);
    repeat (4) tick();
    chk("done_hold", {uio_out, uo_out}, 16'h204A);

    // new_match with commit in DONE
    apply(1, 0, 1, 1, 1);
    drain();
    chk("new_match", {uio_out, uo_out}, 16'h0000);

    // ena low: a pulse must be invisible
    ena = 1'b0;
    ui_in[2] = 1'b1;
    repeat (2) tick();
    ui_in[2] = 1'b0;
    repeat (3) tick();
    ena = 1'b1;
    repeat (4) tick();
    chk("ena_hold", {uio_out, uo_out}, 16'h0000);

    // reset mid-round
    apply(1, 2, 0, 0, 0);
    drain();
    #2 rst_n = 1'b0;
    mon_en = 1'b0;
    #1 chk("async_reset", {uio_out, uo_out}, 16'h0000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    mon_last = 16'h0000;
    mon_en = 1'b1;
    tick();

`ifdef RPS_TIMEOUT_EN
    apply(0, 0, 1, 1, 0);
    repeat (12) tick();
    drain();
    chk("forfeit", {uio_out, uo_out}, 16'h1082);
    apply(0, 0, 0, 0, 1);
    drain();
`endif

    for (int it = 0; it < 60; it++) begin
      r = int'($urandom_range(0, 9));
      if (done || r == 0) begin
        apply(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1);
      end else if (r < 4) begin
        apply(1, int'($urandom_range(0, 3)), 1, int'($urandom_range(0, 3)), 0);
      end else begin
        first = int'($urandom_range(0, 1));
        gap = int'($urandom_range(0, 6));
        if (first == 0) apply(1, int'($urandom_range(0, 3)), 0, 0, 0);
        else            apply(0, 0, 1, int'($urandom_range(0, 3)), 0);
        repeat (gap) tick();
        if (first == 0) apply(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1, int'($urandom_range(0, 3)), 0);
        else            apply(1, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 0);
      end
      drain();
    end

    repeat (20) tick();
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
